// File: rtl/scan_loader_if.sv
// Byte stream between a byte source and scan_loader: program bytes in,
// chain readback bytes out (readback has no backpressure).
interface scan_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/scan_loader.sv
// Shifts bytes MSB-first into the processor scan chain, returns the displaced
// chain bits as readback bytes, and optionally runs the core until halt.
module scan_loader #(
    parameter int CHAIN_BYTES = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          run_after_load,
    scan_loader_if.slave  bus,
    output logic          scan_enable,
    output logic          scan_in,
    input  logic          scan_out,
    output logic          proc_en,
    input  logic          halt,
    output logic          busy,
    output logic          done,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        RUN
    } state_t;

    localparam int BW = (CHAIN_BYTES > 1) ? $clog2(CHAIN_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(CHAIN_BYTES - 1);

    state_t        state_q, state_d;
    logic          run_q, run_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic          halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        byte_cnt_d  = byte_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        halted_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    run_d      = run_after_load;
                    byte_cnt_d = '0;
                    state_d    = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (bus.in_valid) begin
                    tx_d      = bus.in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // scan_out sampled here is the chain bit displaced by the bit now on scan_in
                tx_d      = {tx_q[6:0], 1'b0};
                rx_d      = {rx_q[6:0], scan_out};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    out_data_d  = {rx_q[6:0], scan_out};
                    out_valid_d = 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        done_d  = 1'b1;
                        state_d = run_q ? RUN : IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = WAIT_BYTE;
                    end
                end
            end
            RUN: begin
                if (halt) begin
                    halted_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == WAIT_BYTE);
        bus.out_data  = out_data_q;
        bus.out_valid = out_valid_q;
        scan_enable   = (state_q == SHIFT);
        scan_in       = (state_q == SHIFT) && tx_q[7];
        proc_en       = (state_q == RUN);
        busy          = (state_q != IDLE);
        done          = done_q;
        halted        = halted_q;
    end

endmodule

// File: tb/tb_scan_loader.sv
// Scoreboard bench for scan_loader with a 2-byte behavioural scan chain
// standing in for the processor core.
module tb_scan_loader;

    localparam int CB = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic run_after_load;
    logic scan_enable;
    logic scan_in;
    logic scan_out;
    logic proc_en;
    logic halt;
    logic busy;
    logic done;
    logic halted;

    scan_loader_if bus ();

    scan_loader #(.CHAIN_BYTES(CB)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .run_after_load (run_after_load),
        .bus            (bus),
        .scan_enable    (scan_enable),
        .scan_in        (scan_in),
        .scan_out       (scan_out),
        .proc_en        (proc_en),
        .halt           (halt),
        .busy           (busy),
        .done           (done),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core scan chain model: tail bit leaves on scan_out, scan_in enters at the head
    logic [15:0] chain;
    logic [15:0] chain_preset;
    logic        chain_load;
    always @(posedge clk) begin
        if (chain_load)       chain <= chain_preset;
        else if (scan_enable) chain <= {chain[14:0], scan_in};
    end
    assign scan_out = chain[15];

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t sbq[$];

    logic scan_hist[$];
    int   pe_cnt   = 0;
    int   halt_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (scan_enable) scan_hist.push_back(scan_in);
            if (proc_en) pe_cnt++;
            if (halted) halt_cnt++;
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected out_valid", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("readback byte", 32'(bus.out_data), 32'(e.data));
                    checkOutput("done with final byte", 32'(done), 32'(e.last));
                end
            end else if (done) begin
                checkOutput("done without out_valid", 32'(done), 32'd0);
            end
        end
    end

    task automatic presetChain(input logic [15:0] v);
        chain_preset = v;
        chain_load   = 1'b1;
        @(negedge clk);
        chain_load   = 1'b0;
    endtask

    task automatic startSession(input logic r);
        start          = 1'b1;
        run_after_load = r;
        @(negedge clk);
        start          = 1'b0;
        run_after_load = 1'b0;
    endtask

    // Offers a byte, records the cycle of acceptance, queues its expected readback
    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] exp_rb,
                                 input logic last, output int acc_cyc);
        int k;
        sbq.push_back('{data: exp_rb, last: last});
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) checkOutput("in_ready timeout", 32'd0, 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDone(output int done_cyc);
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) checkOutput("done timeout", 32'd0, 32'd1);
        done_cyc = cyc;
    endtask

    function automatic logic [15:0] outputsPacked();
        return {bus.in_ready, bus.out_valid, bus.out_data, scan_enable, scan_in,
                proc_en, busy, done, halted};
    endfunction

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int acc0, acc1, dc, sidx, pe0, h0, k;
        logic [15:0] bits;

        rst            = 1'b1;
        start          = 1'b0;
        run_after_load = 1'b0;
        halt           = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        chain_load     = 1'b0;
        chain_preset   = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", 32'(outputsPacked()), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] back-to-back load");
        presetChain(16'hBEEF);
        sidx = scan_hist.size();
        startSession(1'b0);
        applyStimulus(8'h12, 8'hBE, 1'b0, acc0);
        applyStimulus(8'h34, 8'hEF, 1'b1, acc1);
        waitDone(dc);
        checkOutput("byte period", 32'(acc1 - acc0), 32'd9);
        checkOutput("done latency", 32'(dc - acc0), 32'd18);
        checkOutput("chain image", 32'(chain), 32'h1234);
        checkOutput("scan_in bit count", 32'(scan_hist.size() - sidx), 32'd16);
        bits = '0;
        for (int i = 0; i < 16 && (sidx + i) < scan_hist.size(); i++)
            bits = {bits[14:0], scan_hist[sidx + i]};
        checkOutput("scan_in sequence", 32'(bits), 32'h1234);
        @(negedge clk);
        checkOutput("idle after load", 32'(busy), 32'd0);

        $display("[TB] source stall");
        presetChain(16'hBEEF);
        startSession(1'b0);
        applyStimulus(8'h12, 8'hBE, 1'b0, acc0);
        k = 0;
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall scan_enable", 32'(scan_enable), 32'd0);
            checkOutput("stall in_ready", 32'(bus.in_ready), 32'd1);
            @(negedge clk);
        end
        applyStimulus(8'h34, 8'hEF, 1'b1, acc1);
        waitDone(dc);
        checkOutput("stalled byte gap", 32'(acc1 - acc0), 32'd14);
        checkOutput("stalled done latency", 32'(dc - acc1), 32'd9);
        checkOutput("stalled chain image", 32'(chain), 32'h1234);
        @(negedge clk);

        $display("[TB] load then run");
        presetChain(16'hBEEF);
        pe0 = pe_cnt;
        h0  = halt_cnt;
        startSession(1'b1);
        applyStimulus(8'h12, 8'hBE, 1'b0, acc0);
        applyStimulus(8'h34, 8'hEF, 1'b1, acc1);
        waitDone(dc);
        checkOutput("proc_en with done", 32'(proc_en), 32'd1);
        repeat (10) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        checkOutput("proc_en after halt", 32'(proc_en), 32'd0);
        checkOutput("halted pulse", 32'(halted), 32'd1);
        checkOutput("busy after halt", 32'(busy), 32'd0);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("proc_en cycles", 32'(pe_cnt - pe0), 32'd11);
        checkOutput("halted pulse count", 32'(halt_cnt - h0), 32'd1);

        $display("[TB] ignored start and in_valid during shift");
        presetChain(16'hBEEF);
        startSession(1'b0);
        sbq.push_back('{data: 8'hBE, last: 1'b0});
        bus.in_data  = 8'h12;
        bus.in_valid = 1'b1;
        checkOutput("ready before first byte", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_data = 8'h55;
        for (int i = 0; i < 8; i++) begin
            start = (i == 3);
            if (i == 7) bus.in_valid = 1'b0;
            checkOutput("shift scan_enable", 32'(scan_enable), 32'd1);
            checkOutput("shift in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("ready for second byte", 32'(bus.in_ready), 32'd1);
        applyStimulus(8'h34, 8'hEF, 1'b1, acc1);
        waitDone(dc);
        checkOutput("ignored-input chain image", 32'(chain), 32'h1234);
        @(negedge clk);

        $display("[TB] reset mid-shift");
        presetChain(16'hBEEF);
        startSession(1'b0);
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("shifting before reset", 32'(scan_enable), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mid-shift reset outputs", 32'(outputsPacked()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset", 32'(outputsPacked()), 32'd0);

        $display("[TB] reload after reset");
        presetChain(16'h5AC3);
        startSession(1'b0);
        applyStimulus(8'hF0, 8'h5A, 1'b0, acc0);
        applyStimulus(8'h0F, 8'hC3, 1'b1, acc1);
        waitDone(dc);
        checkOutput("reload chain image", 32'(chain), 32'hF00F);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
